// File: rtl/cmp_pkg.sv
// Shared types and constants for the min/max window tracker datapath.
package cmp_pkg;

  localparam int DATA_W = 4;
  localparam int IDX_W  = 4;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } cmp_t;

  // Unsigned magnitude comparison of a against b.
  function automatic cmp_t cmp4_fn(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    cmp_t r;
    r.eq = (a == b);
    r.lt = (a < b);
    r.gt = (a > b);
    return r;
  endfunction

endpackage

// File: rtl/cmp4_core.sv
// Purely combinational 4-bit unsigned eq/lt/gt comparator.
module cmp4_core
  import cmp_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output cmp_t              res_o
);

  assign res_o = cmp4_fn(a_i, b_i);

endmodule

// File: rtl/minmax_tracker_4b.sv
// Streaming window statistics: min, max, first-occurrence indices and flat
// flag over each window of WIN unsigned 4-bit samples.
module minmax_tracker_4b
  import cmp_pkg::*;
#(
  parameter int WIN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic [IDX_W-1:0]  out_min_idx,
  output logic [IDX_W-1:0]  out_max_idx,
  output logic              out_flat
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   min_q, min_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic [IDX_W-1:0]    min_idx_q, min_idx_d;
  logic [IDX_W-1:0]    max_idx_q, max_idx_d;

  cmp_t                cmp_min_s;
  cmp_t                cmp_max_s;
  cmp_t                cmp_flat_s;
  logic                accept_s;
  logic                unused_cmp_s;

  cmp4_core u_cmp_min (
    .a_i   (in_data),
    .b_i   (min_q),
    .res_o (cmp_min_s)
  );

  cmp4_core u_cmp_max (
    .a_i   (in_data),
    .b_i   (max_q),
    .res_o (cmp_max_s)
  );

  cmp4_core u_cmp_flat (
    .a_i   (min_q),
    .b_i   (max_q),
    .res_o (cmp_flat_s)
  );

  // Only lt from the min compare, gt from the max compare and eq from the
  // flat compare steer the datapath; the remaining flags are intentionally idle.
  assign unused_cmp_s = ^{cmp_min_s.eq, cmp_min_s.gt,
                          cmp_max_s.eq, cmp_max_s.lt,
                          cmp_flat_s.lt, cmp_flat_s.gt};

  assign accept_s = in_valid && (state_q == ACC);

  // Next-state logic: clear dominates, then window accumulation or result hand-off.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    min_d     = min_q;
    max_d     = max_q;
    min_idx_d = min_idx_q;
    max_idx_d = max_idx_q;

    if (clear) begin
      state_d = ACC;
      cnt_d   = {IDX_W{1'b0}};
    end else begin
      case (state_q)
        ACC: begin
          if (accept_s) begin
            if (cnt_q == {IDX_W{1'b0}}) begin
              min_d     = in_data;
              max_d     = in_data;
              min_idx_d = {IDX_W{1'b0}};
              max_idx_d = {IDX_W{1'b0}};
            end else begin
              // Strict compares keep the first occurrence on ties.
              if (cmp_min_s.lt) begin
                min_d     = in_data;
                min_idx_d = cnt_q;
              end else begin
                min_d     = min_q;
              end
              if (cmp_max_s.gt) begin
                max_d     = in_data;
                max_idx_d = cnt_q;
              end else begin
                max_d     = max_q;
              end
            end
            if (cnt_q == LAST_IDX) begin
              state_d = DONE;
              cnt_d   = {IDX_W{1'b0}};
            end else begin
              cnt_d   = cnt_q + 4'd1;
            end
          end else begin
            state_d = ACC;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = ACC;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = ACC;
          cnt_d   = {IDX_W{1'b0}};
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset to the idle values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACC;
      cnt_q     <= {IDX_W{1'b0}};
      min_q     <= {DATA_W{1'b0}};
      max_q     <= {DATA_W{1'b0}};
      min_idx_q <= {IDX_W{1'b0}};
      max_idx_q <= {IDX_W{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      min_q     <= min_d;
      max_q     <= max_d;
      min_idx_q <= min_idx_d;
      max_idx_q <= max_idx_d;
    end
  end

  assign in_ready    = (state_q == ACC);
  assign out_valid   = (state_q == DONE);
  assign out_min     = min_q;
  assign out_max     = max_q;
  assign out_min_idx = min_idx_q;
  assign out_max_idx = max_idx_q;
  assign out_flat    = cmp_flat_s.eq;

endmodule

// File: doc/minmax_tracker_4b.md
# minmax_tracker_4b

Streaming window statistics stage for 4-bit unsigned samples. It accepts samples over a valid/ready handshake and, for each window of WIN samples, reports the minimum, the maximum, the index of the first occurrence of each, and a flat flag. All ordering decisions come from an eq/lt/gt 4-bit magnitude comparison, so this block is the sequential consumer of that comparison in the datapath.

## Interface
- WIN, default 8: samples per window; legal range 2..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous abort; discards the partial window.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a sample this cycle.
- in_data  input  4  unsigned sample.
- out_valid  output  1  window result available.
- out_ready  input  1  consumer takes the result.
- out_min  output  4  window minimum.
- out_max  output  4  window maximum.
- out_min_idx  output  4  position in the window (0-based) of the first occurrence of the minimum.
- out_max_idx  output  4  position in the window (0-based) of the first occurrence of the maximum.
- out_flat  output  1  1 when out_min == out_max.

## Operation
- **Clock and reset:** one clock, clk. Reset is asynchronous and active-low on rst_n.
- **States:**
  - ACC: accumulating samples.
  - DONE: holding the result.
- **Handshakes:**
  - in_ready = (state == ACC). A sample is accepted when in_valid & in_ready.
  - A result is taken when out_valid & out_ready.
- **Counter:** cnt, 4 bits, counts accepted samples in the current window.
- **First sample of a window (cnt == 0):**
  - min_r = max_r = in_data.
  - Both index registers = 0.
- **Later samples:** compare in_data against min_r and against max_r.
  - If in_data < min_r: min_r = in_data and min_idx = cnt.
  - If in_data > max_r: max_r = in_data and max_idx = cnt.
  - Ties never update, so the first occurrence is kept.
- **Window end:** on the accept where cnt == WIN-1, go to DONE and clear cnt to 0.
- **DONE:**
  - out_valid = 1.
  - Outputs stay stable until taken.
  - in_data is ignored.
  - When the result is taken, return to ACC.
- **Outputs:** out_* are driven directly from the registers. out_flat = eq(min_r, max_r).
- **clear:**
  - Has priority over all other events in both states.
  - Next state is ACC with cnt = 0 and out_valid = 0.
  - A sample presented in the clear cycle is not counted. The block still shows in_ready = 1 in ACC, but the sample is dropped.
  - A result held in DONE is discarded.
- **Arithmetic:** all comparisons are unsigned 4-bit. There is no saturation or overflow path.

## Timing
- **Reset values:**
  - state = ACC, cnt = 0.
  - in_ready = 1 once rst_n is high.
  - out_valid = 0.
  - out_min, out_max, both idx outputs = 0.
  - out_flat = 1.
- **Reset mid-operation:** takes effect immediately, asynchronously, to the values above. The partial window and any held result are lost.
- **Throughput:** one sample per cycle in ACC.
- **Latency:** out_valid rises on the clock edge that accepts the WIN-th sample, so it is visible in the next cycle.
- **DONE to ACC:**
  - The result is taken on cycle t, and in_ready = 1 from cycle t+1.
  - This gives at least one bubble cycle per window.
- **Backpressure:** while out_ready is low, out_valid and all out_* hold for any number of cycles, and in_ready stays 0.
- **Simultaneous clear and out handshake in DONE:** clear wins. Treat the result as dropped, although the consumer may have sampled it.
- in_valid low in ACC: no state change.

## Structure
- **Shared package** (cmp_pkg), holding:
  - DATA_W = 4.
  - typedef state_t {ACC, DONE}.
  - typedef cmp_t (struct of eq, lt, gt).
- **Sub-module:** cmp4_core.
  - Purely combinational 4-bit unsigned eq/lt/gt.
  - Instantiated twice: in_data vs min_r, and in_data vs max_r.
  - A third comparison of min_r vs max_r for out_flat may reuse cmp4_core.
- **Top level:** FSM, counter, and registers only. Estimated 150–250 lines.

## Test plan
All scenarios use WIN = 4.
1. **Distinct values, tied maximum:** in 5, 9, 2, 9 back-to-back, out_ready = 1 → out_min = 2, min_idx = 2, out_max = 9, max_idx = 1, flat = 0. out_valid is high exactly one cycle.
2. **Flat window:** in 7, 7, 7, 7 → min = max = 7, both idx = 0, flat = 1.
3. **Extremes:** in 15, 0, 15, 0 → min = 0, min_idx = 1, max = 15, max_idx = 0.
4. **Backpressure:** out_ready = 0 for 5 cycles after the window completes, with in_valid held high → outputs stable, in_ready = 0, nothing accepted. Then drive out_ready = 1 and send 3, 1, 4, 1 → min = 1, min_idx = 1, max = 4, max_idx = 2.
5. **Clear mid-window:**
   - Send 8, 8, then pulse clear with in_valid = 1 and in_data = 0 in the same cycle.
   - Then send 6, 2, 6, 2.
   - Expected: min = 2, min_idx = 1, max = 6, max_idx = 0. The 0 presented during clear is not counted.
6. **Reset mid-operation:** drive rst_n low between clock edges in DONE and mid-window → out_valid = 0 and all out_* = 0 immediately (flat = 1). The next window of 4 samples completes normally.
